// File: rtl/cgra_harness_pkg.sv
// Shared types and constants for the CGRA harness controller.
package cgra_harness_pkg;

    // Sequencer phases, in the order a normal run walks through them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        FLUSH  = 3'd2,
        RUN    = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } harness_state_t;

    // Config address the fabric treats as "no write this cycle".
    localparam int CFG_NOOP_ADDR = 0;

endpackage

// File: rtl/cgra_harness_ctrl_chan_check.sv
// Per-channel response check: compares one pad sample against stim*mult,
// with the product truncated to the pad width (unsigned wrap is expected).
module harness_chan_check #(
    parameter int PAD_W = 16
) (
    input  logic [PAD_W-1:0] stim,
    input  logic [PAD_W-1:0] mult,
    input  logic [PAD_W-1:0] sample,
    output logic             mismatch
);

    logic [PAD_W-1:0] expected;

    // Self-determined PAD_W multiply keeps only the low PAD_W product bits.
    always_comb begin
        expected = stim * mult;
        mismatch = (sample != expected);
    end

endmodule

// File: rtl/cgra_harness_ctrl.sv
// CGRA harness controller: streams a config bitstream into the fabric,
// drives latched stimulus onto the input pads for a programmed number of
// cycles, then checks each output-pad channel against stimulus * gain.
module cgra_harness_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PAD_W  = 16,
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic                    cfg_valid_in,
    output logic                    cfg_ready_out,
    input  logic [ADDR_W-1:0]       cfg_addr_in,
    input  logic [DATA_W-1:0]       cfg_data_in,
    input  logic                    cfg_last_in,
    input  logic [CNT_W-1:0]        run_cycles_in,
    input  logic [PAD_W-1:0]        mult_in,
    input  logic [NUM_CH*PAD_W-1:0] stim_in,
    output logic [ADDR_W-1:0]       config_addr_out,
    output logic [DATA_W-1:0]       config_data_out,
    output logic [NUM_CH*PAD_W-1:0] pad_drive_out,
    input  logic [NUM_CH*PAD_W-1:0] pad_sample_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    pass_out,
    output logic [NUM_CH-1:0]       fail_mask_out,
    output logic [CNT_W-1:0]        cycle_count_out
);

    import cgra_harness_pkg::*;

    harness_state_t state;

    logic [CNT_W-1:0]        run_q;
    logic [PAD_W-1:0]        mult_q;
    logic [NUM_CH*PAD_W-1:0] stim_q;

    logic [NUM_CH-1:0]       mismatch;
    logic                    cfg_accept;
    logic                    run_last;

    // cfg_ready_out is high exactly while in CONFIG, so this is the handshake.
    assign cfg_accept = cfg_valid_in && cfg_ready_out;

    // Last RUN cycle: run length 0 is treated as 1 so at least one cycle runs.
    assign run_last = (run_q == '0) ? (cycle_count_out == '0)
                                    : (cycle_count_out == run_q - CNT_W'(1));

    // One combinational checker per channel; the verdict is registered in CHECK.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        harness_chan_check #(
            .PAD_W (PAD_W)
        ) u_chan_check (
            .stim     (stim_q[ch*PAD_W +: PAD_W]),
            .mult     (mult_q),
            .sample   (pad_sample_in[ch*PAD_W +: PAD_W]),
            .mismatch (mismatch[ch])
        );
    end

    // Config bus: an accepted word appears for exactly one cycle, else no-op.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            config_addr_out <= ADDR_W'(CFG_NOOP_ADDR);
            config_data_out <= '0;
        end else if (state == CONFIG && cfg_accept) begin
            config_addr_out <= cfg_addr_in;
            config_data_out <= cfg_data_in;
        end else begin
            config_addr_out <= ADDR_W'(CFG_NOOP_ADDR);
            config_data_out <= '0;
        end
    end

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= IDLE;
            run_q           <= '0;
            mult_q          <= '0;
            stim_q          <= '0;
            cfg_ready_out   <= 1'b0;
            pad_drive_out   <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            pass_out        <= 1'b0;
            fail_mask_out   <= '0;
            cycle_count_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        run_q         <= run_cycles_in;
                        mult_q        <= mult_in;
                        stim_q        <= stim_in;
                        busy_out      <= 1'b1;
                        cfg_ready_out <= 1'b1;
                        state         <= CONFIG;
                    end
                end
                CONFIG: begin
                    if (cfg_accept && cfg_last_in) begin
                        cfg_ready_out <= 1'b0;
                        state         <= FLUSH;
                    end
                end
                FLUSH: begin
                    pad_drive_out   <= stim_q;
                    cycle_count_out <= '0;
                    state           <= RUN;
                end
                RUN: begin
                    // Reaches eff on the final RUN edge; eff never exceeds the
                    // counter's maximum, so no wrap is possible.
                    cycle_count_out <= cycle_count_out + CNT_W'(1);
                    if (run_last) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    fail_mask_out <= mismatch;
                    pass_out      <= ~|mismatch;
                    done_out      <= 1'b1;
                    busy_out      <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    if (start_in) begin
                        run_q           <= run_cycles_in;
                        mult_q          <= mult_in;
                        stim_q          <= stim_in;
                        pad_drive_out   <= '0;
                        done_out        <= 1'b0;
                        pass_out        <= 1'b0;
                        fail_mask_out   <= '0;
                        cycle_count_out <= '0;
                        busy_out        <= 1'b1;
                        cfg_ready_out   <= 1'b1;
                        state           <= CONFIG;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_harness_ctrl.sv
// Directed bench for cgra_harness_ctrl with two channels.
module tb_cgra_harness_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PAD_W  = 16;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;

    logic                    clk_in;
    logic                    reset_in;
    logic                    start_in;
    logic                    cfg_valid_in;
    logic                    cfg_ready_out;
    logic [ADDR_W-1:0]       cfg_addr_in;
    logic [DATA_W-1:0]       cfg_data_in;
    logic                    cfg_last_in;
    logic [CNT_W-1:0]        run_cycles_in;
    logic [PAD_W-1:0]        mult_in;
    logic [NUM_CH*PAD_W-1:0] stim_in;
    logic [ADDR_W-1:0]       config_addr_out;
    logic [DATA_W-1:0]       config_data_out;
    logic [NUM_CH*PAD_W-1:0] pad_drive_out;
    logic [NUM_CH*PAD_W-1:0] pad_sample_in;
    logic                    busy_out;
    logic                    done_out;
    logic                    pass_out;
    logic [NUM_CH-1:0]       fail_mask_out;
    logic [CNT_W-1:0]        cycle_count_out;

    int checks = 0;
    int errors = 0;

    cgra_harness_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PAD_W  (PAD_W),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .cfg_valid_in    (cfg_valid_in),
        .cfg_ready_out   (cfg_ready_out),
        .cfg_addr_in     (cfg_addr_in),
        .cfg_data_in     (cfg_data_in),
        .cfg_last_in     (cfg_last_in),
        .run_cycles_in   (run_cycles_in),
        .mult_in         (mult_in),
        .stim_in         (stim_in),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .pad_drive_out   (pad_drive_out),
        .pad_sample_in   (pad_sample_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .pass_out        (pass_out),
        .fail_mask_out   (fail_mask_out),
        .cycle_count_out (cycle_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_seq(input logic [CNT_W-1:0] rc, input logic [PAD_W-1:0] m,
                             input logic [NUM_CH*PAD_W-1:0] s);
        run_cycles_in = rc;
        mult_in       = m;
        stim_in       = s;
        start_in      = 1'b1;
        tick();
        start_in      = 1'b0;
        chk("start_busy",   64'(busy_out),        64'd1);
        chk("start_ready",  64'(cfg_ready_out),   64'd1);
        chk("start_done",   64'(done_out),        64'd0);
        chk("start_pass",   64'(pass_out),        64'd0);
        chk("start_mask",   64'(fail_mask_out),   64'd0);
        chk("start_count",  64'(cycle_count_out), 64'd0);
        chk("start_pad",    64'(pad_drive_out),   64'd0);
    endtask

    // Cycle i offers a word when vpat[i]=1; the final cycle carries last.
    task automatic send_cfg(input int len, input logic [7:0] vpat,
                            input logic [NUM_CH*PAD_W-1:0] s, output int nz);
        int k;
        k  = 0;
        nz = 0;
        for (int i = 0; i < len; i++) begin
            cfg_valid_in = vpat[i];
            cfg_addr_in  = 32'h0000_0100 + 32'(k);
            cfg_data_in  = 32'hD000_0000 + 32'(k);
            cfg_last_in  = (i == len - 1);
            tick();
            if (vpat[i]) begin
                chk("cfg_addr_word", 64'(config_addr_out), 64'h100 + 64'(k));
                chk("cfg_data_word", 64'(config_data_out), 64'hD000_0000 + 64'(k));
                k++;
            end else begin
                chk("cfg_addr_gap", 64'(config_addr_out), 64'd0);
                chk("cfg_data_gap", 64'(config_data_out), 64'd0);
            end
            if (config_addr_out != '0) nz++;
        end
        cfg_valid_in = 1'b0;
        cfg_last_in  = 1'b0;
        chk("flush_ready", 64'(cfg_ready_out), 64'd0);
        chk("flush_pad",   64'(pad_drive_out), 64'd0);
        tick();
        chk("run_cfg_addr", 64'(config_addr_out), 64'd0);
        chk("run_cfg_data", 64'(config_data_out), 64'd0);
        chk("run_pad",      64'(pad_drive_out),   64'(s));
        chk("run_busy",     64'(busy_out),        64'd1);
    endtask

    // Counts ticks until done_out, bounded so the bench always finishes.
    task automatic wait_done(output int n);
        n = 0;
        while (!done_out && n < 70000) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(done_out), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic exp_pass,
                                input logic [NUM_CH-1:0] exp_mask,
                                input logic [CNT_W-1:0] exp_count);
        chk({tag, "_pass"},  64'(pass_out),        64'(exp_pass));
        chk({tag, "_mask"},  64'(fail_mask_out),   64'(exp_mask));
        chk({tag, "_count"}, 64'(cycle_count_out), 64'(exp_count));
        chk({tag, "_busy"},  64'(busy_out),        64'd0);
    endtask

    initial begin
        int nz;
        int n;

        reset_in      = 1'b1;
        start_in      = 1'b0;
        cfg_valid_in  = 1'b0;
        cfg_addr_in   = '0;
        cfg_data_in   = '0;
        cfg_last_in   = 1'b0;
        run_cycles_in = '0;
        mult_in       = '0;
        stim_in       = '0;
        pad_sample_in = '0;
        tick();
        tick();
        chk("rst_ready", 64'(cfg_ready_out),   64'd0);
        chk("rst_addr",  64'(config_addr_out), 64'd0);
        chk("rst_data",  64'(config_data_out), 64'd0);
        chk("rst_pad",   64'(pad_drive_out),   64'd0);
        chk("rst_busy",  64'(busy_out),        64'd0);
        chk("rst_done",  64'(done_out),        64'd0);
        chk("rst_pass",  64'(pass_out),        64'd0);
        chk("rst_mask",  64'(fail_mask_out),   64'd0);
        chk("rst_count", 64'(cycle_count_out), 64'd0);
        reset_in = 1'b0;
        tick();

        // 1: pass case, 3 back-to-back words, 300 run cycles.
        pad_sample_in = {16'h0002, 16'h0300};
        start_seq(16'd300, 16'd2, {16'h0001, 16'h0180});
        send_cfg(3, 8'b0000_0111, {16'h0001, 16'h0180}, nz);
        chk("t1_nz_writes", 64'(nz), 64'd3);
        wait_done(n);
        chk("t1_latency", 64'(3 + 1 + n), 64'd305);
        check_result("t1", 1'b1, 2'b00, 16'd300);
        tick();
        chk("t1_done_hold",  64'(done_out),        64'd1);
        chk("t1_count_hold", 64'(cycle_count_out), 64'd300);
        chk("t1_pad_hold",   64'(pad_drive_out),   64'h0001_0180);

        // 2: fail case, restarted from DONE.
        pad_sample_in = {16'h0002, 16'h0180};
        start_seq(16'd300, 16'd2, {16'h0001, 16'h0180});
        send_cfg(3, 8'b0000_0111, {16'h0001, 16'h0180}, nz);
        wait_done(n);
        check_result("t2", 1'b0, 2'b01, 16'd300);

        // 3: backpressure gaps 1,0,0,1(last).
        pad_sample_in = {16'h0015, 16'h000F};
        start_seq(16'd4, 16'd3, {16'h0007, 16'h0005});
        send_cfg(4, 8'b0000_1001, {16'h0007, 16'h0005}, nz);
        chk("t3_nz_writes", 64'(nz), 64'd2);
        wait_done(n);
        chk("t3_latency", 64'(n), 64'd5);
        check_result("t3", 1'b1, 2'b00, 16'd4);

        // 4: two channels, channel 1 product overflows and truncates.
        pad_sample_in = {16'h0002, 16'h0007};
        start_seq(16'd10, 16'd2, {16'h8001, 16'h0003});
        send_cfg(1, 8'b0000_0001, {16'h8001, 16'h0003}, nz);
        wait_done(n);
        check_result("t4", 1'b0, 2'b01, 16'd10);

        // 5a: run_cycles=0 gives exactly one RUN cycle.
        pad_sample_in = {16'h0000, 16'h0009};
        start_seq(16'd0, 16'd9, {16'h0000, 16'h0001});
        send_cfg(2, 8'b0000_0011, {16'h0000, 16'h0001}, nz);
        wait_done(n);
        chk("t5a_latency", 64'(n), 64'd2);
        check_result("t5a", 1'b1, 2'b00, 16'd1);

        // 5b: start and config traffic during RUN are ignored.
        pad_sample_in = {16'h0004, 16'h0006};
        start_seq(16'd6, 16'd2, {16'h0002, 16'h0003});
        send_cfg(1, 8'b0000_0001, {16'h0002, 16'h0003}, nz);
        start_in      = 1'b1;
        cfg_valid_in  = 1'b1;
        cfg_last_in   = 1'b1;
        cfg_addr_in   = 32'h55;
        run_cycles_in = 16'd100;
        stim_in       = '0;
        tick();
        start_in      = 1'b0;
        cfg_valid_in  = 1'b0;
        cfg_last_in   = 1'b0;
        chk("t5b_cfg_ignored", 64'(config_addr_out), 64'd0);
        chk("t5b_ready_low",   64'(cfg_ready_out),   64'd0);
        chk("t5b_count",       64'(cycle_count_out), 64'd1);
        chk("t5b_pad",         64'(pad_drive_out),   64'h0002_0003);
        wait_done(n);
        chk("t5b_latency", 64'(1 + n), 64'd7);
        check_result("t5b", 1'b1, 2'b00, 16'd6);

        // 6: reset mid-RUN, then a full sequence from IDLE.
        pad_sample_in = {16'h0004, 16'h0006};
        start_seq(16'd50, 16'd2, {16'h0002, 16'h0003});
        send_cfg(1, 8'b0000_0001, {16'h0002, 16'h0003}, nz);
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("t6_rst_pad",   64'(pad_drive_out),   64'd0);
        chk("t6_rst_busy",  64'(busy_out),        64'd0);
        chk("t6_rst_done",  64'(done_out),        64'd0);
        chk("t6_rst_count", 64'(cycle_count_out), 64'd0);
        chk("t6_rst_ready", 64'(cfg_ready_out),   64'd0);
        chk("t6_rst_addr",  64'(config_addr_out), 64'd0);
        tick();
        chk("t6_idle_busy", 64'(busy_out), 64'd0);
        pad_sample_in = {16'h0030, 16'hFFFE};
        start_seq(16'd8, 16'd2, {16'h0018, 16'hFFFF});
        send_cfg(2, 8'b0000_0011, {16'h0018, 16'hFFFF}, nz);
        wait_done(n);
        chk("t6_latency", 64'(n), 64'd9);
        check_result("t6", 1'b1, 2'b00, 16'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
